noc_ram_bridge: RTL and testbench

//  Parametrised successor of the fixed 6-flit NoC-to-RAM path. Accepts flit packets over valid/ready,

---
 rtl/noc_ram_bridge.sv | 167 ++++++++++++++++
 tb/tb_noc_ram_bridge.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_ram_bridge.sv
// rtl/noc_ram_bridge.sv - NoC flit packet to internal RAM bridge (optional tail parity: NOC_RAM_PARITY_EN)
module noc_ram_bridge #(
  parameter int FLIT_WIDTH = 16,
  parameter int BODY_FLITS = 4,
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [FLIT_WIDTH-1:0] i_flit,
  input  logic                  i_flit_valid,
  output logic                  o_flit_ready,
  output logic                  o_wr_ack,
  output logic                  o_rd_valid,
  output logic [DATA_WIDTH-1:0] o_rdata,
  input  logic                  i_rd_ready,
  output logic                  o_err
);

  localparam int BW = FLIT_WIDTH - 2;
  localparam int P  = BODY_FLITS * BW;
  localparam int CW = $clog2(BODY_FLITS + 1);
  localparam logic [CW-1:0] LAST_BODY = CW'(BODY_FLITS - 1);

  localparam logic [1:0] T_HEAD = 2'b01;
  localparam logic [1:0] T_BODY = 2'b00;
  localparam logic [1:0] T_TAIL = 2'b10;

  // Parameter sanity: the payload must hold one address and one data word
  if (BODY_FLITS < 1 || P < ADDR_WIDTH + DATA_WIDTH) begin : g_bad_params
    $error("noc_ram_bridge: payload too small for ADDR_WIDTH+DATA_WIDTH");
  end

  typedef enum logic [2:0] {S_IDLE, S_BODY, S_TAIL, S_EXEC, S_RESP} state_t;

  state_t                  state;
  logic [CW-1:0]           body_cnt;
  logic                    op_write;
  logic [P-1:0]            payload;
  logic [DATA_WIDTH-1:0]   mem [2**ADDR_WIDTH];

  logic                    accept;
  logic [1:0]              flit_type;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-1:0]   wdata;
  logic                    ram_we;

  assign accept    = i_flit_valid & o_flit_ready;
  assign flit_type = i_flit[FLIT_WIDTH-1 -: 2];
  assign addr      = payload[P-1 -: ADDR_WIDTH];
  assign wdata     = payload[P-1-ADDR_WIDTH -: DATA_WIDTH];
  // A write only touches the RAM from EXEC; a reset in that cycle cancels it
  assign ram_we    = (state == S_EXEC) & op_write & ~i_rst;

`ifdef NOC_RAM_PARITY_EN
  logic parity_ok;
  assign parity_ok = (i_flit[0] == ^payload);
`else
  logic unused_payload;
  assign unused_payload = ^payload;
`endif

  // Word-wide RAM write port; contents deliberately not reset
  always_ff @(posedge i_clk) begin
    if (ram_we) begin
      mem[addr] <= wdata;
    end
  end

  // Packet assembly, command execution and registered handshake outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= S_IDLE;
      body_cnt     <= '0;
      op_write     <= 1'b0;
      o_flit_ready <= 1'b0;
      o_wr_ack     <= 1'b0;
      o_rd_valid   <= 1'b0;
      o_err        <= 1'b0;
      o_rdata      <= '0;
    end else begin
      o_wr_ack <= 1'b0;
      o_err    <= 1'b0;
      case (state)
        S_IDLE: begin
          o_flit_ready <= 1'b1;
          if (accept) begin
            if (flit_type == T_HEAD) begin
              state    <= S_BODY;
              body_cnt <= '0;
              op_write <= i_flit[FLIT_WIDTH-3];
            end else begin
              o_err <= 1'b1;
            end
          end
        end
        S_BODY: begin
          if (accept) begin
            if (flit_type == T_HEAD) begin
              o_err    <= 1'b1;
              body_cnt <= '0;
              op_write <= i_flit[FLIT_WIDTH-3];
            end else if (flit_type == T_BODY) begin
              payload  <= (payload << BW) | P'(i_flit[BW-1:0]);
              body_cnt <= body_cnt + 1'b1;
              if (body_cnt == LAST_BODY) begin
                state <= S_TAIL;
              end
            end else begin
              o_err <= 1'b1;
              state <= S_IDLE;
            end
          end
        end
        S_TAIL: begin
          if (accept) begin
            if (flit_type == T_HEAD) begin
              o_err    <= 1'b1;
              state    <= S_BODY;
              body_cnt <= '0;
              op_write <= i_flit[FLIT_WIDTH-3];
            end else if (flit_type == T_TAIL) begin
`ifdef NOC_RAM_PARITY_EN
              if (parity_ok) begin
                state        <= S_EXEC;
                o_flit_ready <= 1'b0;
              end else begin
                o_err <= 1'b1;
                state <= S_IDLE;
              end
`else
              state        <= S_EXEC;
              o_flit_ready <= 1'b0;
`endif
            end else begin
              o_err <= 1'b1;
              state <= S_IDLE;
            end
          end
        end
        S_EXEC: begin
          if (op_write) begin
            o_wr_ack     <= 1'b1;
            o_flit_ready <= 1'b1;
            state        <= S_IDLE;
          end else begin
            o_rdata    <= mem[addr];
            o_rd_valid <= 1'b1;
            state      <= S_RESP;
          end
        end
        S_RESP: begin
          if (i_rd_ready) begin
            o_rd_valid   <= 1'b0;
            o_flit_ready <= 1'b1;
            state        <= S_IDLE;
          end
        end
        default: begin
          state        <= S_IDLE;
          o_flit_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_noc_ram_bridge.sv
// tb/tb_noc_ram_bridge.sv - directed self-checking bench for noc_ram_bridge
module tb_noc_ram_bridge;

  localparam int FW = 16;
  localparam int AW = 14;
  localparam int DW = 32;
  localparam int P  = 56;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic [FW-1:0] i_flit = '0;
  logic          i_flit_valid = 1'b0;
  logic          o_flit_ready;
  logic          o_wr_ack;
  logic          o_rd_valid;
  logic [DW-1:0] o_rdata;
  logic          i_rd_ready = 1'b0;
  logic          o_err;

  int vectors = 0;
  int miscompares = 0;

  noc_ram_bridge #(.FLIT_WIDTH(FW), .BODY_FLITS(4), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_flit(i_flit), .i_flit_valid(i_flit_valid),
    .o_flit_ready(o_flit_ready), .o_wr_ack(o_wr_ack), .o_rd_valid(o_rd_valid),
    .o_rdata(o_rdata), .i_rd_ready(i_rd_ready), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [P-1:0] mk_payload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    return {a, d, {(P-AW-DW){1'b0}}};
  endfunction

  task automatic send_flit(input logic [FW-1:0] f);
    i_flit = f;
    i_flit_valid = 1'b1;
    vectors++;
    if (o_flit_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL flit_ready before flit %h: got %b want 1", f, o_flit_ready);
    end
    tick();
    i_flit_valid = 1'b0;
    i_flit = '0;
  endtask

  task automatic send_bodies(input logic [P-1:0] pl, input int n);
    for (int i = 0; i < n; i++) send_flit({2'b00, pl[P-1-14*i -: 14]});
  endtask

  task automatic send_tail(input logic [P-1:0] pl, input logic bad);
    send_flit({2'b10, 13'b0, (^pl) ^ bad});
  endtask

  // Full write packet; returns o_err one cycle after the tail and o_wr_ack two cycles after
  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic bad,
                          output logic err1, output logic ack2);
    logic [P-1:0] pl;
    pl = mk_payload(a, d);
    send_flit(16'h6000);
    send_bodies(pl, 4);
    send_tail(pl, bad);
    err1 = o_err;
    tick();
    ack2 = o_wr_ack;
  endtask

  task automatic do_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output logic ok);
    logic [P-1:0] pl;
    pl = mk_payload(a, '0);
    ok = 1'b0;
    d = '0;
    i_rd_ready = 1'b1;
    send_flit(16'h4000);
    send_bodies(pl, 4);
    send_tail(pl, 1'b0);
    for (int n = 0; n < 10 && !ok; n++) begin
      tick();
      if (o_rd_valid === 1'b1) begin
        d = o_rdata;
        ok = 1'b1;
        tick();
      end
    end
    i_rd_ready = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    tick();
    vectors++;
    if ({o_flit_ready, o_wr_ack, o_rd_valid, o_err} !== 4'b0 || o_rdata !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got rdy=%b ack=%b rv=%b err=%b rdata=%h want all 0",
               o_flit_ready, o_wr_ack, o_rd_valid, o_err, o_rdata);
    end
    i_rst = 1'b0;
    tick();
    vectors++;
    if (o_flit_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release_ready: got %b want 1", o_flit_ready);
    end
  endtask

  task automatic test_write();
    logic [P-1:0] pl;
    pl = mk_payload(14'h0005, 32'hDEADBEEF);
    send_flit(16'h6000);
    send_bodies(pl, 4);
    send_tail(pl, 1'b0);
    vectors++;
    if ({o_wr_ack, o_flit_ready, o_err} !== 3'b000) begin
      miscompares++;
      $display("FAIL write_exec: got ack=%b rdy=%b err=%b want 0 0 0", o_wr_ack, o_flit_ready, o_err);
    end
    tick();
    vectors++;
    if ({o_wr_ack, o_flit_ready, o_err} !== 3'b110) begin
      miscompares++;
      $display("FAIL write_ack: got ack=%b rdy=%b err=%b want 1 1 0", o_wr_ack, o_flit_ready, o_err);
    end
    tick();
    vectors++;
    if (o_wr_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL write_ack_pulse: got %b want 0", o_wr_ack);
    end
  endtask

  task automatic test_read_hold();
    logic [P-1:0] pl;
    pl = mk_payload(14'h0005, '0);
    i_rd_ready = 1'b0;
    send_flit(16'h4000);
    send_bodies(pl, 4);
    send_tail(pl, 1'b0);
    vectors++;
    if ({o_rd_valid, o_flit_ready} !== 2'b00) begin
      miscompares++;
      $display("FAIL read_exec: got rv=%b rdy=%b want 0 0", o_rd_valid, o_flit_ready);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (o_rd_valid !== 1'b1 || o_rdata !== 32'hDEADBEEF || o_flit_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL read_hold[%0d]: got rv=%b rdata=%h rdy=%b want 1 deadbeef 0",
                 i, o_rd_valid, o_rdata, o_flit_ready);
      end
    end
    i_rd_ready = 1'b1;
    tick();
    i_rd_ready = 1'b0;
    vectors++;
    if ({o_rd_valid, o_flit_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL read_release: got rv=%b rdy=%b want 0 1", o_rd_valid, o_flit_ready);
    end
  endtask

  task automatic test_idle_body();
    logic e, a, ok;
    logic [DW-1:0] d;
    send_flit(16'h0123);
    vectors++;
    if (o_err !== 1'b1) begin
      miscompares++;
      $display("FAIL idle_body_err: got %b want 1", o_err);
    end
    tick();
    vectors++;
    if (o_err !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_body_err_pulse: got %b want 0", o_err);
    end
    do_write(14'h3FFF, 32'h12345678, 1'b0, e, a);
    vectors++;
    if ({e, a} !== 2'b01) begin
      miscompares++;
      $display("FAIL write_3fff: got err=%b ack=%b want 0 1", e, a);
    end
    do_read(14'h3FFF, d, ok);
    vectors++;
    if (!ok || d !== 32'h12345678) begin
      miscompares++;
      $display("FAIL read_3fff: got ok=%b data=%h want 1 12345678", ok, d);
    end
  endtask

  task automatic test_restart();
    logic [P-1:0] pl;
    logic ok;
    logic [DW-1:0] d;
    send_flit(16'h6000);
    send_bodies(mk_payload(14'h0002, 32'h0), 2);
    send_flit(16'h6000);
    vectors++;
    if (o_err !== 1'b1) begin
      miscompares++;
      $display("FAIL restart_err: got %b want 1", o_err);
    end
    pl = mk_payload(14'h0001, 32'hA5A5A5A5);
    send_bodies(pl, 4);
    send_tail(pl, 1'b0);
    tick();
    vectors++;
    if ({o_wr_ack, o_err} !== 2'b10) begin
      miscompares++;
      $display("FAIL restart_ack: got ack=%b err=%b want 1 0", o_wr_ack, o_err);
    end
    do_read(14'h0001, d, ok);
    vectors++;
    if (!ok || d !== 32'hA5A5A5A5) begin
      miscompares++;
      $display("FAIL read_0001: got ok=%b data=%h want 1 a5a5a5a5", ok, d);
    end
  endtask

  task automatic test_malformed();
    logic [P-1:0] pl;
    pl = mk_payload(14'h0030, 32'h0F0F0F0F);
    send_flit(16'h6000);
    send_bodies(pl, 2);
    send_flit(16'h8000);
    vectors++;
    if (o_err !== 1'b1) begin
      miscompares++;
      $display("FAIL tail_in_body_err: got %b want 1", o_err);
    end
    send_flit(16'h0000);
    vectors++;
    if (o_err !== 1'b1) begin
      miscompares++;
      $display("FAIL dropped_to_idle_err: got %b want 1", o_err);
    end
    send_flit(16'h6000);
    send_bodies(pl, 4);
    send_flit(16'hC000);
    vectors++;
    if (o_err !== 1'b1) begin
      miscompares++;
      $display("FAIL invalid_at_tail_err: got %b want 1", o_err);
    end
    tick();
    vectors++;
    if ({o_wr_ack, o_flit_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL invalid_at_tail_noack: got ack=%b rdy=%b want 0 1", o_wr_ack, o_flit_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic e1, a1, e2, a2, ok;
    logic [DW-1:0] d;
    do_write(14'h0100, 32'h01020304, 1'b0, e1, a1);
    do_write(14'h0101, 32'hCAFEF00D, 1'b0, e2, a2);
    vectors++;
    if ({e1, a1, e2, a2} !== 4'b0101) begin
      miscompares++;
      $display("FAIL b2b_acks: got e1=%b a1=%b e2=%b a2=%b want 0 1 0 1", e1, a1, e2, a2);
    end
    do_read(14'h0100, d, ok);
    vectors++;
    if (!ok || d !== 32'h01020304) begin
      miscompares++;
      $display("FAIL b2b_read_0100: got ok=%b data=%h want 1 01020304", ok, d);
    end
    do_read(14'h0101, d, ok);
    vectors++;
    if (!ok || d !== 32'hCAFEF00D) begin
      miscompares++;
      $display("FAIL b2b_read_0101: got ok=%b data=%h want 1 cafef00d", ok, d);
    end
  endtask

  task automatic test_reset_mid();
    logic e, a, ok;
    logic [DW-1:0] d;
    do_write(14'h0010, 32'h11112222, 1'b0, e, a);
    send_flit(16'h6000);
    send_bodies(mk_payload(14'h0010, 32'hBADBAD00), 3);
    i_rst = 1'b1;
    tick();
    vectors++;
    if ({o_flit_ready, o_wr_ack, o_rd_valid, o_err} !== 4'b0 || o_rdata !== '0) begin
      miscompares++;
      $display("FAIL mid_reset_outputs: got rdy=%b ack=%b rv=%b err=%b rdata=%h want all 0",
               o_flit_ready, o_wr_ack, o_rd_valid, o_err, o_rdata);
    end
    i_rst = 1'b0;
    tick();
    do_read(14'h0010, d, ok);
    vectors++;
    if (!ok || d !== 32'h11112222) begin
      miscompares++;
      $display("FAIL read_0010_after_reset: got ok=%b data=%h want 1 11112222", ok, d);
    end
  endtask

`ifdef NOC_RAM_PARITY_EN
  task automatic test_parity();
    logic e, a, ok;
    logic [DW-1:0] d;
    do_write(14'h0020, 32'h0BADF00D, 1'b0, e, a);
    do_write(14'h0020, 32'hFFFF0000, 1'b1, e, a);
    vectors++;
    if ({e, a} !== 2'b10) begin
      miscompares++;
      $display("FAIL bad_parity: got err=%b ack=%b want 1 0", e, a);
    end
    do_read(14'h0020, d, ok);
    vectors++;
    if (!ok || d !== 32'h0BADF00D) begin
      miscompares++;
      $display("FAIL bad_parity_unchanged: got ok=%b data=%h want 1 0badf00d", ok, d);
    end
    do_write(14'h0020, 32'hFFFF0000, 1'b0, e, a);
    vectors++;
    if ({e, a} !== 2'b01) begin
      miscompares++;
      $display("FAIL good_parity: got err=%b ack=%b want 0 1", e, a);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read_hold();
    test_idle_body();
    test_restart();
    test_malformed();
    test_back_to_back();
    test_reset_mid();
`ifdef NOC_RAM_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
